// File: rtl/jts16b_pkg.sv
// Shared definitions for the System 16B main-CPU RAM controller:
// FSM encoding, default SDRAM bases and region ids used in the read-buffer tag.
package jts16b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [21:0] DEF_RAM_OFFSET  = 22'h10_0000;
  localparam logic [21:0] DEF_VRAM_OFFSET = 22'h10_2000;

  // Region id forms the MSB of the read-buffer tag
  localparam logic REG_RAM  = 1'b0;
  localparam logic REG_VRAM = 1'b1;

  localparam int TAG_W = 15;

endpackage

// File: rtl/jts16b_ramctl_rdbuf.sv
// One-word read buffer: tag/data register with hit compare and byte merge
// of writes that land on the buffered word.
module jts16b_ramctl_rdbuf
  import jts16b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic [15:0]      data,
  input  logic             fill,
  input  logic [15:0]      fill_data,
  input  logic             merge,
  input  logic [TAG_W-1:0] up_tag,
  input  logic [15:0]      wr_data,
  input  logic [1:0]       wr_mask
);

  logic             valid_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [15:0]      data_reg;
  logic [15:0]      merged;

  // A set mask bit means that byte was not written, so keep the old byte
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_byte
      assign merged[gi*8 +: 8] = wr_mask[gi] ? data_reg[gi*8 +: 8] : wr_data[gi*8 +: 8];
    end
  endgenerate

  assign hit  = valid_reg && (tag_reg == lk_tag);
  assign data = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      tag_reg   <= up_tag;
      data_reg  <= fill_data;
    end else if (merge && valid_reg && (tag_reg == up_tag)) begin
      data_reg  <= merged;
    end
  end

endmodule

// File: rtl/jts16b_ramctl.sv
// Main-CPU work/tile RAM controller: one SDRAM bank-0 slot transaction per
// chip-select rising edge, with a one-word read buffer and response timeout.
module jts16b_ramctl
  import jts16b_pkg::*;
#(
  parameter int           AW          = 22,
  parameter logic [AW-1:0] RAM_OFFSET  = AW'(DEF_RAM_OFFSET),
  parameter logic [AW-1:0] VRAM_OFFSET = AW'(DEF_VRAM_OFFSET),
  parameter int           TOUT        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ram_cs,
  input  logic          vram_cs,
  input  logic [13:0]   addr,
  input  logic [15:0]   cpu_dout,
  input  logic [1:0]    dswn,
  output logic [15:0]   ram_data,
  output logic          ram_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  output logic          sdram_we,
  output logic [1:0]    sdram_wrmask,
  output logic [15:0]   sdram_din,
  input  logic [15:0]   sdram_dout,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  output logic          tout_err
);

  state_t           state_reg;
  logic             cs_l_reg;
  logic [TOUT-1:0]  cnt_reg;
  logic [TAG_W-1:0] tag_reg;

  logic             cs, cs_edge, rd_req, busy, rsp, tmo, hit;
  logic [TAG_W-1:0] lk_tag;
  logic [15:0]      buf_data;
  logic [AW-1:0]    map_addr;

  assign cs      = ram_cs | vram_cs;
  assign cs_edge = cs & ~cs_l_reg;
  assign rd_req  = (dswn == 2'b11);
  assign lk_tag  = {(vram_cs ? REG_VRAM : REG_RAM), addr};

  // Work RAM is 8k words, so only addr[13:1] reaches SDRAM; tile RAM uses all 14 bits
  assign map_addr = vram_cs ? VRAM_OFFSET + AW'(addr)
                            : RAM_OFFSET  + AW'(addr[13:1]);

  assign busy = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  // rdy together with ack is a complete response straight out of REQ
  assign rsp  = ((state_reg == ST_WAIT) && sdram_rdy) ||
                ((state_reg == ST_REQ) && sdram_ack && sdram_rdy);
  assign tmo  = busy && !rsp && (cnt_reg == '1);

  jts16b_ramctl_rdbuf u_rdbuf (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmo),
    .lk_tag    (lk_tag),
    .hit       (hit),
    .data      (buf_data),
    .fill      (rsp && !sdram_we),
    .fill_data (sdram_dout),
    .merge     (rsp && sdram_we),
    .up_tag    (tag_reg),
    .wr_data   (sdram_din),
    .wr_mask   (sdram_wrmask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cs_l_reg     <= 1'b0;
      cnt_reg      <= '0;
      tag_reg      <= '0;
      ram_data     <= '0;
      ram_ok       <= 1'b0;
      sdram_addr   <= '0;
      sdram_req    <= 1'b0;
      sdram_we     <= 1'b0;
      sdram_wrmask <= '0;
      sdram_din    <= '0;
      tout_err     <= 1'b0;
    end else begin
      cs_l_reg <= cs;
      case (state_reg)
        ST_IDLE: begin
          ram_ok <= 1'b0;
          if (cs_edge) begin
            if (rd_req && hit) begin
              ram_data  <= buf_data;
              ram_ok    <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              sdram_addr   <= map_addr;
              sdram_we     <= ~rd_req;
              sdram_wrmask <= dswn;
              sdram_din    <= cpu_dout;
              sdram_req    <= 1'b1;
              tag_reg      <= lk_tag;
              cnt_reg      <= '0;
              state_reg    <= ST_REQ;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          if (rsp) begin
            sdram_req <= 1'b0;
            if (!sdram_we) ram_data <= sdram_dout;
            // An aborted access finishes silently
            ram_ok    <= cs;
            state_reg <= cs ? ST_DONE : ST_IDLE;
          end else if (tmo) begin
            tout_err  <= 1'b1;
            sdram_req <= 1'b0;
            if (cs) begin
              ram_ok   <= 1'b1;
              ram_data <= 16'hffff;
            end
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if ((state_reg == ST_REQ) && sdram_ack) begin
              sdram_req <= 1'b0;
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          if (!cs) begin
            ram_ok    <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jts16b_ramctl.sv
// Bench for jts16b_ramctl: transaction-level model of the SDRAM contents and
// the one-word read buffer, per-cycle compare, plus pinned literal cases.
module tb_jts16b_ramctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_cs = 1'b0, vram_cs = 1'b0;
  logic [13:0] addr = '0;
  logic [15:0] cpu_dout = '0;
  logic [1:0]  dswn = 2'b11;
  logic [15:0] ram_data;
  logic        ram_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req, sdram_we;
  logic [1:0]  sdram_wrmask;
  logic [15:0] sdram_din;
  logic [15:0] sdram_dout = '0;
  logic        sdram_ack = 1'b0, sdram_rdy = 1'b0;
  logic        tout_err;

  jts16b_ramctl dut (
    .clk(clk), .rst(rst), .ram_cs(ram_cs), .vram_cs(vram_cs), .addr(addr),
    .cpu_dout(cpu_dout), .dswn(dswn), .ram_data(ram_data), .ram_ok(ram_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_we(sdram_we),
    .sdram_wrmask(sdram_wrmask), .sdram_din(sdram_din), .sdram_dout(sdram_dout),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle
  logic        exp_ok = 0, exp_req = 0, exp_err = 0, exp_rd = 0, exp_we = 0;
  logic [15:0] exp_data = '0, exp_din = '0;
  logic [21:0] exp_addr = '0;
  logic [1:0]  exp_mask = '0;
  bit          chk_en = 0, skip = 0;

  // Model: SDRAM words and the read buffer
  logic [15:0] mem [logic [21:0]];
  bit          bvalid = 0;
  logic [14:0] btag = '0;
  logic [15:0] bdata = '0;

  // What the DUT showed in the last transfer
  logic        seen_req, seen_we, seen_ok;
  logic [21:0] seen_addr;
  logic [1:0]  seen_mask;
  logic [15:0] seen_din, seen_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !skip) begin
      chk("ram_ok", 64'(ram_ok), 64'(exp_ok));
      if (exp_ok && exp_rd) chk("ram_data", 64'(ram_data), 64'(exp_data));
      chk("sdram_req", 64'(sdram_req), 64'(exp_req));
      if (exp_req)
        chk("sdram_cmd", 64'({sdram_addr, sdram_we, sdram_wrmask, sdram_din}),
            64'({exp_addr, exp_we, exp_mask, exp_din}));
      chk("tout_err", 64'(tout_err), 64'(exp_err));
    end
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_rd(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'h5a5a);
  endfunction

  // Bytes whose strobe is low (0) take the new data
  function automatic logic [15:0] wmerge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] ds);
    logic [15:0] r;
    r[15:8] = ds[1] ? old[15:8] : nw[15:8];
    r[7:0]  = ds[0] ? old[7:0]  : nw[7:0];
    return r;
  endfunction

  task automatic xfer(input bit vr, input logic [13:0] a, input logic [1:0] ds,
                      input logic [15:0] wd, input int ack_d, input int rdy_d,
                      input bit abort, input int hold);
    logic [21:0] m;
    logic [14:0] tag;
    logic [15:0] rdat;
    bit rd, hit, ab;
    rd   = (ds == 2'b11);
    tag  = {vr, a};
    hit  = rd && bvalid && (btag == tag);
    ab   = abort && !hit && (rdy_d >= 2);
    m    = vr ? 22'h10_2000 + {8'd0, a} : 22'h10_0000 + {9'd0, a[13:1]};
    ram_cs = !vr; vram_cs = vr; addr = a; dswn = ds; cpu_dout = wd;
    step();
    seen_req = sdram_req; seen_addr = sdram_addr; seen_we = sdram_we;
    seen_mask = sdram_wrmask; seen_din = sdram_din;
    exp_rd = rd;
    if (hit) begin
      exp_ok = 1; exp_data = bdata;
    end else begin
      exp_req = 1; exp_addr = m; exp_we = !rd; exp_mask = ds; exp_din = wd;
      repeat (ack_d) step();
      rdat = mem_rd(m);
      sdram_ack = 1;
      if (rdy_d == 0) begin
        sdram_rdy = 1; sdram_dout = rd ? rdat : 16'($urandom);
      end
      step();
      sdram_ack = 0; sdram_rdy = 0; exp_req = 0;
      if (rdy_d > 0) begin
        if (ab) begin ram_cs = 0; vram_cs = 0; end
        repeat (rdy_d - 1) step();
        sdram_rdy = 1; sdram_dout = rd ? rdat : 16'($urandom);
        step();
        sdram_rdy = 0;
      end
      if (rd) begin
        bvalid = 1; btag = tag; bdata = rdat;
      end else begin
        mem[m] = wmerge(mem_rd(m), wd, ds);
        if (bvalid && btag == tag) bdata = wmerge(bdata, wd, ds);
      end
      if (!ab) begin exp_ok = 1; exp_data = rdat; end
    end
    seen_ok = ram_ok; seen_data = ram_data;
    if (!ab) begin
      // cs stays high while the address moves: no new request allowed
      repeat (hold) begin addr = 14'($urandom); step(); end
      ram_cs = 0; vram_cs = 0;
      step();
      exp_ok = 0;
    end
  endtask

  task automatic timeout_test();
    int n;
    ram_cs = 1; vram_cs = 0; addr = 14'h0123; dswn = 2'b00; cpu_dout = 16'h0bad;
    step();
    skip = 1;
    n = 0;
    while (ram_ok !== 1'b1 && n < 400) begin step(); n++; end
    chk("tout_ok", 64'(ram_ok), 64'(1));
    chk("tout_data", 64'(ram_data), 64'(16'hffff));
    chk("tout_flag", 64'(tout_err), 64'(1));
    chk("tout_req_drop", 64'(sdram_req), 64'(0));
    chk("tout_window", 64'(n >= 250 && n <= 260), 64'(1));
    exp_err = 1; exp_ok = 1; exp_rd = 1; exp_data = 16'hffff; exp_req = 0;
    bvalid = 0;
    skip = 0;
    ram_cs = 0;
    step();
    exp_ok = 0;
  endtask

  task automatic reset_test();
    skip = 1;
    ram_cs = 1; vram_cs = 0; addr = 14'h0200; dswn = 2'b11;
    step();
    chk("rst_req_before", 64'(sdram_req), 64'(1));
    rst = 1;
    step();
    chk("rst_req_cleared", 64'(sdram_req), 64'(0));
    chk("rst_ok", 64'(ram_ok), 64'(0));
    chk("rst_err_cleared", 64'(tout_err), 64'(0));
    rst = 0; ram_cs = 0; sdram_ack = 1; sdram_rdy = 1; sdram_dout = 16'hdead;
    step();
    sdram_ack = 0; sdram_rdy = 0;
    chk("stale_rdy_ok", 64'(ram_ok), 64'(0));
    chk("stale_rdy_req", 64'(sdram_req), 64'(0));
    bvalid = 0; exp_err = 0; exp_ok = 0; exp_req = 0;
    skip = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vr;
    logic [13:0] a;
    logic [1:0] ds;
    repeat (3) step();
    chk("reset_ram_ok", 64'(ram_ok), 64'(0));
    chk("reset_ram_data", 64'(ram_data), 64'(0));
    chk("reset_outputs", 64'({sdram_req, sdram_we, sdram_wrmask, sdram_addr, sdram_din, tout_err}), 64'(0));
    rst = 0;
    chk_en = 1;

    mem[22'h10_0008] = 16'h1234;
    xfer(0, 14'h0010, 2'b11, 16'h0000, 2, 3, 0, 2);
    chk("p1_addr", 64'(seen_addr), 64'(22'h10_0008));
    chk("p1_we", 64'(seen_we), 64'(0));
    chk("p1_ok", 64'(seen_ok), 64'(1));
    chk("p1_data", 64'(seen_data), 64'(16'h1234));

    xfer(0, 14'h0010, 2'b11, 16'h0000, 0, 0, 0, 1);
    chk("p2_no_req", 64'(seen_req), 64'(0));
    chk("p2_data", 64'(seen_data), 64'(16'h1234));

    xfer(0, 14'h0010, 2'b10, 16'hAB55, 1, 2, 0, 0);
    chk("p3_cmd", 64'({seen_we, seen_mask, seen_din}), 64'({1'b1, 2'b10, 16'hAB55}));
    xfer(0, 14'h0010, 2'b11, 16'h0000, 0, 0, 0, 0);
    chk("p3_hit_req", 64'(seen_req), 64'(0));
    chk("p3_hit_data", 64'(seen_data), 64'(16'h1255));

    xfer(1, 14'h2001, 2'b11, 16'h0000, 0, 0, 0, 3);
    chk("p4_vram_addr", 64'(seen_addr), 64'(22'h10_4001));

    xfer(0, 14'h0100, 2'b11, 16'h0000, 1, 4, 1, 0);
    chk("p5_abort_ok", 64'(seen_ok), 64'(0));
    repeat (2) step();
    xfer(0, 14'h0102, 2'b11, 16'h0000, 1, 1, 0, 0);
    chk("p5_after_abort_ok", 64'(seen_ok), 64'(1));

    timeout_test();
    reset_test();

    for (int i = 0; i < 80; i++) begin
      vr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0, 1:    ds = 2'b11;
        2:       ds = 2'b10;
        3:       ds = 2'b01;
        default: ds = 2'b00;
      endcase
      xfer(vr, a, ds, 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
    end
    repeat (3) step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
